// File: rtl/mips_alu_unit_if.sv
// Execute-stage ALU bus: instruction fields and operands in, decoded op and result out.
// Latency: ALUop is combinational, Out/out_valid arrive one Clock after in_valid.
// Backpressure: none; the ALU accepts a new operation every cycle.
//   master: drives in_valid, opcode, funct, A, B; observes ALUop, Out, out_valid
//   slave : the ALU side of the same bus
interface mips_alu_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [3:0]       ALUop;
  logic [WIDTH-1:0] Out;
  logic             out_valid;

  modport master (
    output in_valid, opcode, funct, A, B,
    input  ALUop, Out, out_valid
  );

  modport slave (
    input  in_valid, opcode, funct, A, B,
    output ALUop, Out, out_valid
  );
endinterface

// File: rtl/mips_alu_unit.sv
// MIPS150 execute-stage ALU: decodes opcode/funct to a 4-bit op and computes the 32-bit result.
// Latency: ALUop combinational; Out and out_valid registered, one Clock after in_valid.
// Backpressure: none; every valid cycle is accepted, idle cycles hold Out and drop out_valid.
//   Clock : rising-edge clock
//   Reset : asynchronous active-high reset, clears Out and out_valid
//   bus   : slave side of mips_alu_unit_if (in_valid/opcode/funct/A/B in, ALUop/Out/out_valid out)
module mips_alu_unit #(
  parameter int WIDTH = 32  // only 32 is supported
) (
  input  logic           Clock,
  input  logic           Reset,
  mips_alu_unit_if.slave bus
);

  localparam logic [3:0] OP_ADDU = 4'd0;
  localparam logic [3:0] OP_SUBU = 4'd1;
  localparam logic [3:0] OP_SLT  = 4'd2;
  localparam logic [3:0] OP_SLTU = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_LUI  = 4'd7;
  localparam logic [3:0] OP_SLL  = 4'd8;
  localparam logic [3:0] OP_SRA  = 4'd9;
  localparam logic [3:0] OP_SRL  = 4'd10;
  localparam logic [3:0] OP_NOR  = 4'd11;
  localparam logic [3:0] OP_XXX  = 4'd15;

  logic [3:0]       alu_op;
  logic [WIDTH-1:0] result;
  logic [4:0]       shamt;

  // Decoder. funct only matters for R-type; loads/stores reuse ADDU for
  // address generation, everything else (branches, jumps, undefined) is XXX.
  always_comb begin
    alu_op = OP_XXX;
    if (bus.opcode == 6'b000000) begin
      case (bus.funct)
        6'b000000, 6'b000100: alu_op = OP_SLL;
        6'b000010, 6'b000110: alu_op = OP_SRL;
        6'b000011, 6'b000111: alu_op = OP_SRA;
        6'b100001:            alu_op = OP_ADDU;
        6'b100011:            alu_op = OP_SUBU;
        6'b100100:            alu_op = OP_AND;
        6'b100101:            alu_op = OP_OR;
        6'b100110:            alu_op = OP_XOR;
        6'b100111:            alu_op = OP_NOR;
        6'b101010:            alu_op = OP_SLT;
        6'b101011:            alu_op = OP_SLTU;
        default:              alu_op = OP_XXX;
      endcase
    end else begin
      case (bus.opcode)
        6'b001001: alu_op = OP_ADDU;
        6'b001010: alu_op = OP_SLT;
        6'b001011: alu_op = OP_SLTU;
        6'b001100: alu_op = OP_AND;
        6'b001101: alu_op = OP_OR;
        6'b001110: alu_op = OP_XOR;
        6'b001111: alu_op = OP_LUI;
        6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101,
        6'b101000, 6'b101001, 6'b101011:
                   alu_op = OP_ADDU;
        default:   alu_op = OP_XXX;
      endcase
    end
  end

  assign bus.ALUop = alu_op;

  // Shift amount comes from A[4:0] for both immediate and variable shifts;
  // upstream muxing has already placed shamt there.
  assign shamt = bus.A[4:0];

  always_comb begin
    result = '0;
    case (alu_op)
      OP_ADDU: result = bus.A + bus.B;
      OP_SUBU: result = bus.A - bus.B;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
      OP_SLTU: result = {{(WIDTH-1){1'b0}}, (bus.A < bus.B)};
      OP_AND:  result = bus.A & bus.B;
      OP_OR:   result = bus.A | bus.B;
      OP_XOR:  result = bus.A ^ bus.B;
      OP_NOR:  result = ~(bus.A | bus.B);
      OP_LUI:  result = {bus.B[15:0], 16'h0000};
      OP_SLL:  result = bus.B << shamt;
      OP_SRL:  result = bus.B >> shamt;
      OP_SRA:  result = $unsigned($signed(bus.B) >>> shamt);
      default: result = '0;
    endcase
  end

  // Out holds across idle cycles so downstream can sample it late;
  // out_valid marks only the cycle after an accepted operation.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      bus.Out       <= '0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.out_valid <= bus.in_valid;
      if (bus.in_valid) begin
        bus.Out <= result;
      end
    end
  end

endmodule

// File: tb/tb_mips_alu_unit.sv
// Testbench for mips_alu_unit: directed plan vectors plus randomized operations against a reference model.
// Latency: checks ALUop before the edge and Out/out_valid 1 time unit after it.
// Backpressure: none exercised; the DUT has no stall input.
module tb_mips_alu_unit;

  logic Clock;
  logic Reset;
  int   total;
  int   bad;

  logic [31:0] exp_out;
  logic        exp_vld;

  mips_alu_unit_if #(.WIDTH(32)) bus ();

  mips_alu_unit #(.WIDTH(32)) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Reference decode, straight from the instruction table.
  function automatic logic [3:0] ref_op(input logic [5:0] opc, input logic [5:0] fn);
    logic [3:0] r;
    r = 4'd15;
    if (opc == 6'd0) begin
      case (fn)
        6'h00, 6'h04: r = 4'd8;
        6'h02, 6'h06: r = 4'd10;
        6'h03, 6'h07: r = 4'd9;
        6'h21: r = 4'd0;
        6'h23: r = 4'd1;
        6'h24: r = 4'd4;
        6'h25: r = 4'd5;
        6'h26: r = 4'd6;
        6'h27: r = 4'd11;
        6'h2a: r = 4'd2;
        6'h2b: r = 4'd3;
        default: r = 4'd15;
      endcase
    end else begin
      case (opc)
        6'h09: r = 4'd0;
        6'h0a: r = 4'd2;
        6'h0b: r = 4'd3;
        6'h0c: r = 4'd4;
        6'h0d: r = 4'd5;
        6'h0e: r = 4'd6;
        6'h0f: r = 4'd7;
        6'h20, 6'h21, 6'h23, 6'h24, 6'h25, 6'h28, 6'h29, 6'h2b: r = 4'd0;
        default: r = 4'd15;
      endcase
    end
    return r;
  endfunction

  // Reference result computed with 64-bit integer arithmetic (modulo, division, powers of two).
  function automatic logic [31:0] ref_res(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, sb, p, m, r;
    int sh;
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m  = 64'sh1_0000_0000;
    sh = int'(a % 32);
    p  = longint'(64'd1) << sh;
    r  = 0;
    case (op)
      4'd0:  r = (ua + ub) % m;
      4'd1:  r = (ua - ub + m) % m;
      4'd2:  r = (sa < sb) ? 1 : 0;
      4'd3:  r = (ua < ub) ? 1 : 0;
      4'd4:  r = ua & ub;
      4'd5:  r = ua | ub;
      4'd6:  r = ua ^ ub;
      4'd7:  r = (ub % 65536) * 65536;
      4'd8:  r = (ub * p) % m;
      4'd9:  r = ((sb >= 0) ? (sb / p) : ((sb - (p - 1)) / p) + m) % m;
      4'd10: r = ub / p;
      4'd11: r = (m - 1) - (ua | ub);
      default: r = 0;
    endcase
    return r[31:0];
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One cycle of stimulus. want/use_want adds a check against a hand-derived constant.
  task automatic do_op(input string tag, input logic [5:0] opc, input logic [5:0] fn,
                       input logic [31:0] a, input logic [31:0] b, input logic v,
                       input logic use_want, input logic [31:0] want);
    logic [3:0] op;
    @(negedge Clock);
    bus.opcode   = opc;
    bus.funct    = fn;
    bus.A        = a;
    bus.B        = b;
    bus.in_valid = v;
    op = ref_op(opc, fn);
    #1;
    check({tag, ".aluop"}, {28'd0, bus.ALUop}, {28'd0, op});
    if (v) exp_out = ref_res(op, a, b);
    exp_vld = v;
    @(posedge Clock);
    #1;
    check({tag, ".out"}, bus.Out, exp_out);
    check({tag, ".vld"}, {31'd0, bus.out_valid}, {31'd0, exp_vld});
    if (use_want) check({tag, ".want"}, bus.Out, want);
  endtask

  logic [5:0] opc_pool [0:15];

  initial begin
    total = 0;
    bad   = 0;
    exp_out = '0;
    exp_vld = 1'b0;
    bus.in_valid = 1'b0;
    bus.opcode   = '0;
    bus.funct    = '0;
    bus.A        = '0;
    bus.B        = '0;
    Reset = 1'b1;
    #12;
    check("reset.out", bus.Out, 32'h0);
    check("reset.vld", {31'd0, bus.out_valid}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;

    // Load 0x1234, then reset asynchronously mid-cycle.
    do_op("pre", 6'h00, 6'h21, 32'h1234, 32'h0, 1'b1, 1'b1, 32'h1234);
    @(negedge Clock);
    bus.in_valid = 1'b1;
    #2 Reset = 1'b1;
    #1;
    check("arst.out", bus.Out, 32'h0);
    check("arst.vld", {31'd0, bus.out_valid}, 32'd0);
    @(posedge Clock);
    #1;
    check("hold.out", bus.Out, 32'h0);
    check("hold.vld", {31'd0, bus.out_valid}, 32'd0);
    @(negedge Clock);
    Reset = 1'b0;
    exp_out = '0;
    exp_vld = 1'b0;

    do_op("addu_wrap", 6'h00, 6'h21, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b1, 32'h0);
    do_op("subu",  6'h00, 6'h23, 32'h0, 32'h1, 1'b1, 1'b1, 32'hFFFFFFFF);
    do_op("slt",   6'h00, 6'h2a, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b1, 32'h1);
    do_op("sltu",  6'h00, 6'h2b, 32'hFFFFFFFF, 32'h1, 1'b1, 1'b1, 32'h0);
    do_op("slti",  6'h0a, 6'h00, 32'h5, 32'h5, 1'b1, 1'b1, 32'h0);
    do_op("andi",  6'h0c, 6'h3f, 32'hF0F0F0F0, 32'h0000FFFF, 1'b1, 1'b1, 32'h0000F0F0);
    do_op("nor",   6'h00, 6'h27, 32'h0, 32'h0, 1'b1, 1'b1, 32'hFFFFFFFF);
    do_op("lui",   6'h0f, 6'h00, 32'h0, 32'h0000ABCD, 1'b1, 1'b1, 32'hABCD0000);
    do_op("xori",  6'h0e, 6'h00, 32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b1, 32'hFFFFFFFF);
    do_op("sra",   6'h00, 6'h03, 32'h4, 32'h80000000, 1'b1, 1'b1, 32'hF8000000);
    do_op("srl",   6'h00, 6'h02, 32'h4, 32'h80000000, 1'b1, 1'b1, 32'h08000000);
    do_op("sllv",  6'h00, 6'h04, 32'h21, 32'h3, 1'b1, 1'b1, 32'h6);
    do_op("sll",   6'h00, 6'h00, 32'd31, 32'h1, 1'b1, 1'b1, 32'h80000000);
    do_op("lw",    6'h23, 6'h15, 32'h1000, 32'hFFFFFFFC, 1'b1, 1'b1, 32'h00000FFC);
    do_op("sw",    6'h2b, 6'h2a, 32'h1000, 32'hFFFFFFFC, 1'b1, 1'b1, 32'h00000FFC);
    do_op("beq",   6'h04, 6'h21, 32'h1234, 32'h5678, 1'b1, 1'b1, 32'h0);
    do_op("j",     6'h02, 6'h00, 32'h1234, 32'h5678, 1'b1, 1'b1, 32'h0);
    do_op("jr",    6'h00, 6'h08, 32'h1234, 32'h5678, 1'b1, 1'b1, 32'h0);

    // Single pulse then idle: out_valid for one cycle, Out holds.
    do_op("pulse", 6'h09, 6'h00, 32'h10, 32'h20, 1'b1, 1'b1, 32'h30);
    do_op("idle1", 6'h00, 6'h21, 32'h99, 32'h1, 1'b0, 1'b1, 32'h30);
    do_op("idle2", 6'h0f, 6'h00, 32'h7, 32'h7, 1'b0, 1'b1, 32'h30);

    opc_pool[0]  = 6'h00; opc_pool[1]  = 6'h00; opc_pool[2]  = 6'h00; opc_pool[3]  = 6'h09;
    opc_pool[4]  = 6'h0a; opc_pool[5]  = 6'h0b; opc_pool[6]  = 6'h0c; opc_pool[7]  = 6'h0d;
    opc_pool[8]  = 6'h0e; opc_pool[9]  = 6'h0f; opc_pool[10] = 6'h23; opc_pool[11] = 6'h2b;
    opc_pool[12] = 6'h20; opc_pool[13] = 6'h04; opc_pool[14] = 6'h02; opc_pool[15] = 6'h00;

    for (int i = 0; i < 300; i++) begin
      logic [5:0]  ro, rf;
      logic [31:0] ra, rb;
      logic        rv;
      ro = ($urandom_range(0, 7) == 0) ? 6'($urandom) : opc_pool[$urandom_range(0, 15)];
      rf = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'(32'h20 + $urandom_range(0, 11));
      if ($urandom_range(0, 3) == 0) rf = 6'($urandom_range(0, 7));
      ra = $urandom;
      rb = ($urandom_range(0, 1) == 0) ? $urandom : (32'h80000000 | $urandom);
      rv = ($urandom_range(0, 3) != 0);
      do_op("rand", ro, rf, ra, rb, rv, 1'b0, 32'h0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
